// File: rtl/data_out_merge.sv
// data_out_merge: merges two ap_vld/ap_ack streams into one output stream.
// The two inputs are served round-robin in bursts of BURST_LEN words. A burst
// is released early once the granted input has been idle for IDLE_TIMEOUT
// cycles. Accepted words pass through a 2-entry output FIFO.
// Optional macro DATA_OUT_MERGE_STATS_EN adds per-input transfer counters and
// a count of bursts that ended by timeout.
module data_out_merge #(
  parameter int DATA_BITS    = 32,
  parameter int BURST_LEN    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic                 ap_ready,
  input  logic [DATA_BITS-1:0] Input_1_V_V,
  input  logic                 Input_1_V_V_ap_vld,
  output logic                 Input_1_V_V_ap_ack,
  input  logic [DATA_BITS-1:0] Input_2_V_V,
  input  logic                 Input_2_V_V_ap_vld,
  output logic                 Input_2_V_V_ap_ack,
  output logic [DATA_BITS-1:0] Output_1_V_V,
  output logic                 Output_1_V_V_ap_vld,
  input  logic                 Output_1_V_V_ap_ack
`ifdef DATA_OUT_MERGE_STATS_EN
  ,
  output logic [31:0]          stat_cnt_1,
  output logic [31:0]          stat_cnt_2,
  output logic [15:0]          stat_timeout
`endif
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  // Counter values seen in the cycle that completes a burst / a timeout.
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t         state_reg, state_next;
  logic           rr_next_reg, rr_next_next;   // 0: input 1 next, 1: input 2 next
  logic [BW-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [IW-1:0]  idle_cnt_reg, idle_cnt_next;

  logic [DATA_BITS-1:0] buf_mem [2];
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [1:0]           count_reg;

  logic                 xfer_1, xfer_2, push, pop;
  logic                 grant_vld, other_vld;
  logic                 burst_end, timeout_end;
  logic [DATA_BITS-1:0] push_data;

  // Acks depend only on registered state, never on the downstream ack.
  assign Input_1_V_V_ap_ack = ap_start && (state_reg == GRANT1) && (count_reg != 2'd2);
  assign Input_2_V_V_ap_ack = ap_start && (state_reg == GRANT2) && (count_reg != 2'd2);

  assign xfer_1    = Input_1_V_V_ap_ack && Input_1_V_V_ap_vld;
  assign xfer_2    = Input_2_V_V_ap_ack && Input_2_V_V_ap_vld;
  assign push      = xfer_1 || xfer_2;
  assign push_data = xfer_1 ? Input_1_V_V : Input_2_V_V;
  assign pop       = (count_reg != 2'd0) && Output_1_V_V_ap_ack;

  assign Output_1_V_V_ap_vld = (count_reg != 2'd0);
  assign Output_1_V_V        = (count_reg != 2'd0) ? buf_mem[rd_ptr_reg] : '0;
  assign ap_idle             = (state_reg == IDLE) && (count_reg == 2'd0);
  assign ap_done             = burst_end;
  assign ap_ready            = burst_end;

  // Arbitration next-state: grant selection, burst/idle counting, release.
  always_comb begin
    state_next     = state_reg;
    rr_next_next   = rr_next_reg;
    burst_cnt_next = burst_cnt_reg;
    idle_cnt_next  = idle_cnt_reg;
    burst_end      = 1'b0;
    timeout_end    = 1'b0;
    grant_vld      = (state_reg == GRANT1) ? Input_1_V_V_ap_vld : Input_2_V_V_ap_vld;
    other_vld      = (state_reg == GRANT1) ? Input_2_V_V_ap_vld : Input_1_V_V_ap_vld;
    case (state_reg)
      IDLE: begin
        if (ap_start) begin
          if (Input_1_V_V_ap_vld && Input_2_V_V_ap_vld)
            state_next = rr_next_reg ? GRANT2 : GRANT1;
          else if (Input_1_V_V_ap_vld)
            state_next = GRANT1;
          else if (Input_2_V_V_ap_vld)
            state_next = GRANT2;
        end
      end
      GRANT1, GRANT2: begin
        // With ap_start low the grant and both counters are frozen.
        if (ap_start) begin
          if (push) begin
            burst_cnt_next = burst_cnt_reg + BW'(1);
            idle_cnt_next  = '0;
            burst_end      = (burst_cnt_reg == BURST_LAST);
          end else if (!grant_vld) begin
            idle_cnt_next = idle_cnt_reg + IW'(1);
            timeout_end   = (idle_cnt_reg == IDLE_LAST);
            burst_end     = timeout_end;
          end
          if (burst_end) begin
            burst_cnt_next = '0;
            idle_cnt_next  = '0;
            rr_next_next   = (state_reg == GRANT1);
            if (other_vld)
              state_next = (state_reg == GRANT1) ? GRANT2 : GRANT1;
            else if (grant_vld)
              state_next = state_reg;
            else
              state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg     <= IDLE;
      rr_next_reg   <= 1'b0;
      burst_cnt_reg <= '0;
      idle_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rr_next_reg   <= rr_next_next;
      burst_cnt_reg <= burst_cnt_next;
      idle_cnt_reg  <= idle_cnt_next;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge ap_clk) begin
    if (push) buf_mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy; reset discards any held words.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef DATA_OUT_MERGE_STATS_EN
  // Transfer counters wrap; timeout counter saturates.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_cnt_1   <= '0;
      stat_cnt_2   <= '0;
      stat_timeout <= '0;
    end else begin
      if (xfer_1) stat_cnt_1 <= stat_cnt_1 + 32'd1;
      if (xfer_2) stat_cnt_2 <= stat_cnt_2 + 32'd1;
      if (timeout_end && (stat_timeout != 16'hFFFF)) stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_out_merge.sv
// Bench for data_out_merge: table-driven traffic scenarios plus hand-written
// sequences for timeout, backpressure, ap_start gating and async reset.
module tb_data_out_merge;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int IT = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_idle, ap_done, ap_ready;
  logic [DW-1:0] Input_1_V_V = '0, Input_2_V_V = '0;
  logic          Input_1_V_V_ap_vld = 1'b0, Input_2_V_V_ap_vld = 1'b0;
  logic          Input_1_V_V_ap_ack, Input_2_V_V_ap_ack;
  logic [DW-1:0] Output_1_V_V;
  logic          Output_1_V_V_ap_vld;
  logic          Output_1_V_V_ap_ack = 1'b0;
`ifdef DATA_OUT_MERGE_STATS_EN
  logic [31:0]   stat_cnt_1, stat_cnt_2;
  logic [15:0]   stat_timeout;
`endif

  data_out_merge #(.DATA_BITS(DW), .BURST_LEN(BL), .IDLE_TIMEOUT(IT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .Input_1_V_V(Input_1_V_V), .Input_1_V_V_ap_vld(Input_1_V_V_ap_vld),
    .Input_1_V_V_ap_ack(Input_1_V_V_ap_ack),
    .Input_2_V_V(Input_2_V_V), .Input_2_V_V_ap_vld(Input_2_V_V_ap_vld),
    .Input_2_V_V_ap_ack(Input_2_V_V_ap_ack),
    .Output_1_V_V(Output_1_V_V), .Output_1_V_V_ap_vld(Output_1_V_V_ap_vld),
    .Output_1_V_V_ap_ack(Output_1_V_V_ap_ack)
`ifdef DATA_OUT_MERGE_STATS_EN
    , .stat_cnt_1(stat_cnt_1), .stat_cnt_2(stat_cnt_2), .stat_timeout(stat_timeout)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int n1;        // words offered on input 1
    int n2;        // words offered on input 2
    int ack_mode;  // 0: output always acked, 1: random output ack
    int exp_done;  // ap_done pulses while output words are still pending
    int exp_span;  // cycles from first to last output word, -1 = not checked
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int out_mode = 0;   // 0 always ack, 1 random, 2 held low
  int in1_q[$], in2_q[$], exp_q[$];
  int x1, x2, ack1_hi, ack2_hi, done_data;
  int first_out, last_out, first_x2, last_x1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_inputs();
    Input_1_V_V_ap_vld = (in1_q.size() > 0);
    Input_1_V_V        = (in1_q.size() > 0) ? in1_q[0] : 0;
    Input_2_V_V_ap_vld = (in2_q.size() > 0);
    Input_2_V_V        = (in2_q.size() > 0) ? in2_q[0] : 0;
    case (out_mode)
      0:       Output_1_V_V_ap_ack = 1'b1;
      1:       Output_1_V_V_ap_ack = 1'($urandom_range(0, 1));
      default: Output_1_V_V_ap_ack = 1'b0;
    endcase
  endtask

  // One clock: sample handshakes at negedge, update producers after posedge.
  task automatic tick();
    logic s1, s2;
    @(negedge ap_clk);
    cyc++;
    s1 = Input_1_V_V_ap_ack && Input_1_V_V_ap_vld;
    s2 = Input_2_V_V_ap_ack && Input_2_V_V_ap_vld;
    if (ap_done && exp_q.size() > 0) done_data++;
    if (Input_1_V_V_ap_ack) ack1_hi++;
    if (Input_2_V_V_ap_ack) ack2_hi++;
    if (s1) begin x1++; last_x1 = cyc; end
    if (s2) begin x2++; if (first_x2 < 0) first_x2 = cyc; end
    if (Output_1_V_V_ap_vld && Output_1_V_V_ap_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", Output_1_V_V, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("tx cycle %0d out=%0d expect=%0d", cyc, Output_1_V_V, e);
        check("out_word", Output_1_V_V, e);
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    @(posedge ap_clk);
    #1;
    if (s1) void'(in1_q.pop_front());
    if (s2) void'(in2_q.pop_front());
    drive_inputs();
  endtask

  task automatic clear_stats();
    x1 = 0; x2 = 0; ack1_hi = 0; ack2_hi = 0; done_data = 0;
    first_out = -1; last_out = -1; first_x2 = -1; last_x1 = -1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    ap_start = 1'b0;
    in1_q.delete(); in2_q.delete(); exp_q.delete();
    drive_inputs();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    clear_stats();
  endtask

  // Offer n1/n2 words and queue the expected merge order: bursts of BL,
  // switching to the other input whenever it still has words.
  task automatic load(int n1, int n2, int b1, int b2);
    int rem [2];
    int nxt [2];
    int cur;
    rem[0] = n1; rem[1] = n2; nxt[0] = b1; nxt[1] = b2;
    for (int i = 0; i < n1; i++) in1_q.push_back(b1 + i);
    for (int i = 0; i < n2; i++) in2_q.push_back(b2 + i);
    cur = (n1 > 0) ? 0 : 1;
    while (rem[0] + rem[1] > 0) begin
      int take;
      take = (rem[cur] < BL) ? rem[cur] : BL;
      for (int i = 0; i < take; i++) begin
        exp_q.push_back(nxt[cur]);
        nxt[cur]++;
      end
      rem[cur] -= take;
      if (rem[1 - cur] > 0) cur = 1 - cur;
    end
    drive_inputs();
  endtask

  task automatic run_drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{n1: 8, n2: 8, ack_mode: 0, exp_done: 4, exp_span: 15};
    vecs[1] = '{n1: 0, n2: 6, ack_mode: 0, exp_done: 1, exp_span: 5};
    vecs[2] = '{n1: 6, n2: 3, ack_mode: 1, exp_done: 2, exp_span: -1};
    vecs[3] = '{n1: 5, n2: 5, ack_mode: 0, exp_done: 3, exp_span: -1};
    vecs[4] = '{n1: 2, n2: 0, ack_mode: 0, exp_done: 0, exp_span: 1};

    // Reset state
    clear_stats();
    drive_inputs();
    #1 ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_ack1", Input_1_V_V_ap_ack, 0);
    check("rst_ack2", Input_2_V_V_ap_ack, 0);
    check("rst_out_vld", Output_1_V_V_ap_vld, 0);
    check("rst_out_data", Output_1_V_V, 0);
    check("rst_done", ap_done, 0);
    ap_rst = 1'b0;
    tick();
    check("post_rst_idle", ap_idle, 1);

    // Table-driven traffic scenarios
    foreach (vecs[i]) begin
      do_reset();
      out_mode = vecs[i].ack_mode;
      ap_start = 1'b1;
      load(vecs[i].n1, vecs[i].n2, 1, 101);
      run_drain(600);
      check("done_data", done_data, vecs[i].exp_done);
      if (vecs[i].exp_span >= 0) check("span", last_out - first_out, vecs[i].exp_span);
      if (vecs[i].n1 == 0) check("ack1_never", ack1_hi, 0);
      repeat (20) tick();
      check("x1_total", x1, vecs[i].n1);
      check("x2_total", x2, vecs[i].n2);
      check("idle_end", ap_idle, 1);
    end

    // Idle timeout releases a partial burst
    do_reset();
    out_mode = 0;
    ap_start = 1'b1;
    in1_q = '{1, 2};
    in2_q = '{201, 202, 203};
    exp_q = '{1, 2, 201, 202, 203};
    drive_inputs();
    run_drain(100);
    check("to_done", done_data, 1);
    check("to_gap_ok", ((first_x2 - last_x1) >= IT + 1) && ((first_x2 - last_x1) <= IT + 2), 1);
    repeat (15) tick();
`ifdef DATA_OUT_MERGE_STATS_EN
    check("stat_timeout", stat_timeout, 2);
    check("stat_cnt_1", stat_cnt_1, 2);
    check("stat_cnt_2", stat_cnt_2, 3);
`endif

    // Output backpressure: only two words fit
    do_reset();
    out_mode = 2;
    ap_start = 1'b1;
    load(5, 0, 1, 101);
    repeat (12) tick();
    #1;
    check("bp_accepted", x1, 2);
    check("bp_ack_low", Input_1_V_V_ap_ack, 0);
    check("bp_out_vld", Output_1_V_V_ap_vld, 1);
    check("bp_out_head", Output_1_V_V, 1);
    out_mode = 0;
    drive_inputs();
    run_drain(100);
    check("bp_total", x1, 5);

    // ap_start low mid-burst freezes the grant and burst count
    do_reset();
    out_mode = 0;
    ap_start = 1'b1;
    load(6, 4, 1, 101);
    for (int n = 0; n < 50 && x1 < 2; n++) tick();
    ap_start = 1'b0;
    ack1_hi = 0;
    ack2_hi = 0;
    repeat (6) tick();
    check("start_low_acks", ack1_hi + ack2_hi, 0);
    check("start_low_x1", x1, 2);
    ap_start = 1'b1;
    run_drain(100);
    check("start_done", done_data, 2);

    // Async reset mid-burst, then round-robin pointer back to input 1
    do_reset();
    out_mode = 0;
    ap_start = 1'b1;
    load(8, 8, 1, 101);
    repeat (7) tick();
    @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check("arst_ack1", Input_1_V_V_ap_ack, 0);
    check("arst_ack2", Input_2_V_V_ap_ack, 0);
    check("arst_out_vld", Output_1_V_V_ap_vld, 0);
    check("arst_out_data", Output_1_V_V, 0);
    check("arst_done", ap_done, 0);
    check("arst_ready", ap_ready, 0);
    @(posedge ap_clk);
    #1;
    do_reset();
    check("arst_idle", ap_idle, 1);
    ap_start = 1'b1;
    in1_q = '{7};
    in2_q = '{9};
    exp_q = '{7, 9};
    drive_inputs();
    run_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
